// File: rtl/ilb_line_store.sv
// Two-line buffer producing a 2x3 window of the rows above each raster pixel.
// Define ILB_ZERO_PAD_EN to force taps that fall outside the frame to zero.
module ilb_line_store #(
    parameter int IMG_WIDTH  = 28,
    parameter int IMG_HEIGHT = 28
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sop_to_ilb_rts_I,
    output logic                          sop_to_ilb_rtr_I,
    input  logic [7:0]                    pixel_in,
    output logic                          sop_to_ilb_rts_II,
    input  logic                          sop_to_ilb_rtr_II,
    output logic [7:0]                    ilb_byte_0,
    output logic [7:0]                    ilb_byte_1,
    output logic [7:0]                    ilb_byte_2,
    output logic [7:0]                    ilb_byte_3,
    output logic [7:0]                    ilb_byte_4,
    output logic [7:0]                    ilb_byte_5,
    output logic [$clog2(IMG_WIDTH)-1:0]  col_idx,
    output logic [$clog2(IMG_HEIGHT)-1:0] row_idx
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] C_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] R_LAST = RW'(IMG_HEIGHT - 1);

    typedef enum logic [1:0] {IDLE, UPDATE, PRESENT, DONE} state_t;

    state_t          state;
    state_t          state_next;
    logic [7:0]      line1 [IMG_WIDTH];
    logic [7:0]      line2 [IMG_WIDTH];
    logic [7:0]      pix_q;
    logic [2:0][7:0] t1;
    logic [2:0][7:0] t2;
    logic [CW-1:0]   c;
    logic [RW-1:0]   r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Handshake outputs are held low during reset even though the state is already IDLE.
    always_comb begin
        state_next        = state;
        sop_to_ilb_rtr_I  = 1'b0;
        sop_to_ilb_rts_II = 1'b0;
        case (state)
            IDLE: begin
                sop_to_ilb_rtr_I = ~rst;
                if (sop_to_ilb_rts_I) begin
                    state_next = UPDATE;
                end
            end
            UPDATE: begin
                state_next = PRESENT;
            end
            PRESENT: begin
                sop_to_ilb_rts_II = ~rst;
                if (sop_to_ilb_rtr_II) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            t1      <= '0;
            t2      <= '0;
            c       <= '0;
            r       <= '0;
            col_idx <= '0;
            row_idx <= '0;
        end else begin
            if (state == IDLE && sop_to_ilb_rts_I) begin
                pix_q <= pixel_in;
            end
            if (state == UPDATE) begin
                t1      <= {t1[1:0], line1[c]};
                t2      <= {t2[1:0], line2[c]};
                col_idx <= c;
                row_idx <= r;
                if (c == C_LAST) begin
                    c <= '0;
                    r <= (r == R_LAST) ? '0 : r + 1'b1;
                end else begin
                    c <= c + 1'b1;
                end
            end
        end
    end

    // Line memories are deliberately left unreset; the column read above sees the pre-write value.
    always_ff @(posedge clk) begin
        if (!rst && state == UPDATE) begin
            line2[c] <= line1[c];
            line1[c] <= pix_q;
        end
    end

`ifdef ILB_ZERO_PAD_EN
    logic row2_ok;
    logic row1_ok;
    logic col2_ok;
    logic col1_ok;

    assign row2_ok = (row_idx >= RW'(2));
    assign row1_ok = (row_idx >= RW'(1));
    assign col2_ok = (col_idx >= CW'(2));
    assign col1_ok = (col_idx >= CW'(1));

    assign ilb_byte_0 = (row2_ok && col2_ok) ? t2[2] : 8'd0;
    assign ilb_byte_1 = (row2_ok && col1_ok) ? t2[1] : 8'd0;
    assign ilb_byte_2 = row2_ok ? t2[0] : 8'd0;
    assign ilb_byte_3 = (row1_ok && col2_ok) ? t1[2] : 8'd0;
    assign ilb_byte_4 = (row1_ok && col1_ok) ? t1[1] : 8'd0;
    assign ilb_byte_5 = row1_ok ? t1[0] : 8'd0;
`else
    assign ilb_byte_0 = t2[2];
    assign ilb_byte_1 = t2[1];
    assign ilb_byte_2 = t2[0];
    assign ilb_byte_3 = t1[2];
    assign ilb_byte_4 = t1[1];
    assign ilb_byte_5 = t1[0];
`endif

endmodule

// File: tb/tb_ilb_line_store.sv
// Bench for ilb_line_store: vector table streamed through a tap scoreboard, plus
// hand sequences for reset, latency, back-pressure and reset during presentation.
module tb_ilb_line_store;

    localparam int W = 4;
    localparam int H = 4;
    localparam int NVEC = 17;
`ifdef ILB_ZERO_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       rts_i;
    logic       rtr_i;
    logic [7:0] pixel_in;
    logic       rts_ii;
    logic       rtr_ii;
    logic [7:0] b0, b1, b2, b3, b4, b5;
    logic [1:0] col_idx;
    logic [1:0] row_idx;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] pix;
        int         exp_col;
        int         exp_row;
    } vec_t;

    typedef struct packed {
        logic [47:0] taps;
        logic [5:0]  valid;
        logic [7:0]  col;
        logic [7:0]  row;
    } exp_t;

    vec_t       vecs [NVEC];
    exp_t       sb [$];
    logic [7:0] img [H][W];

    ilb_line_store #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk               (clk),
        .rst               (rst),
        .sop_to_ilb_rts_I  (rts_i),
        .sop_to_ilb_rtr_I  (rtr_i),
        .pixel_in          (pixel_in),
        .sop_to_ilb_rts_II (rts_ii),
        .sop_to_ilb_rtr_II (rtr_ii),
        .ilb_byte_0        (b0),
        .ilb_byte_1        (b1),
        .ilb_byte_2        (b2),
        .ilb_byte_3        (b3),
        .ilb_byte_4        (b4),
        .ilb_byte_5        (b5),
        .col_idx           (col_idx),
        .row_idx           (row_idx)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [47:0] tap_vec();
        return {b5, b4, b3, b2, b1, b0};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic doReset(input int n);
        rst      = 1'b1;
        rts_i    = 1'b0;
        rtr_ii   = 1'b0;
        pixel_in = 8'd0;
        repeat (n) tick();
        rst = 1'b0;
    endtask

    // Offer a pixel at a negedge once ready is seen; returns at the negedge after the accept edge.
    task automatic applyStimulus(input logic [7:0] pix, output bit accepted);
        accepted = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (rtr_i) begin
                rts_i    = 1'b1;
                pixel_in = pix;
                tick();
                rts_i    = 1'b0;
                accepted = 1'b1;
                break;
            end
            tick();
        end
        if (!accepted) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout actual=no_ready required=ready pix=%0h", pix);
        end
    endtask

    task automatic waitPresent(input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (rts_ii) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_timeout actual=rts_low required=rts_high", name);
        end
    endtask

    function automatic exp_t model_push(input logic [7:0] pix, input int r, input int c);
        exp_t e;
        int   rr;
        int   cc;
        bit   v;
        img[r][c] = pix;
        e.taps  = '0;
        e.valid = '0;
        e.col   = 8'(c);
        e.row   = 8'(r);
        for (int k = 0; k < 6; k++) begin
            rr = (k < 3) ? r - 2 : r - 1;
            cc = c - 2 + (k % 3);
            v  = (rr >= 0) && (cc >= 0);
            if (v) e.taps[8*k +: 8] = img[rr][cc];
            e.valid[k] = v || PAD;
        end
        return e;
    endfunction

    initial begin
        bit          ok;
        exp_t        e;
        logic [47:0] snap;
        logic [47:0] got;
        logic [47:0] snap9;

        for (int i = 0; i < NVEC; i++) begin
            vecs[i].pix     = 8'(i + 1);
            vecs[i].exp_col = i % W;
            vecs[i].exp_row = (i / W) % H;
        end
        snap9 = '0;

        // Reset and idle
        doReset(0);
        rst = 1'b1;
        repeat (3) tick();
        checkOutput("rst_rtr_i", rtr_i, 0);
        checkOutput("rst_rts_ii", rts_ii, 0);
        checkOutput("rst_taps", tap_vec(), 0);
        rst = 1'b0;
        tick();
        checkOutput("idle_rtr_i", rtr_i, 1);
        checkOutput("idle_rts_ii", rts_ii, 0);
        checkOutput("idle_taps", tap_vec(), 0);
        checkOutput("idle_col", col_idx, 0);
        checkOutput("idle_row", row_idx, 0);

        // Latency and handshake with the consumer always ready
        rtr_ii   = 1'b1;
        rts_i    = 1'b1;
        pixel_in = 8'h11;
        tick();
        rts_i = 1'b0;
        checkOutput("lat_c1_rts_ii", rts_ii, 0);
        checkOutput("lat_c1_rtr_i", rtr_i, 0);
        tick();
        checkOutput("lat_c2_rts_ii", rts_ii, 1);
        checkOutput("lat_c2_col", col_idx, 0);
        tick();
        checkOutput("lat_c3_rts_ii", rts_ii, 0);
        checkOutput("lat_c3_rtr_i", rtr_i, 0);
        tick();
        checkOutput("lat_c4_rtr_i", rtr_i, 1);

        // Table stream: three full rows, a fourth, then wrap into a new frame
        doReset(2);
        rtr_ii = 1'b1;
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].pix, ok);
            if (!ok) break;
            sb.push_back(model_push(vecs[i].pix, vecs[i].exp_row, vecs[i].exp_col));
            waitPresent($sformatf("vec%0d", i), ok);
            if (!ok) break;
            e   = sb.pop_front();
            got = tap_vec();
            if (i == 8) snap9 = got;
            for (int k = 0; k < 6; k++) begin
                if (e.valid[k]) begin
                    checkOutput($sformatf("vec%0d_byte%0d", i, k), got[8*k +: 8], e.taps[8*k +: 8]);
                end
            end
            checkOutput($sformatf("vec%0d_col", i), col_idx, e.col);
            checkOutput($sformatf("vec%0d_row", i), row_idx, e.row);
            tick();
        end

        // Pixel 9 at row 2, column 0
        checkOutput("pix9_byte2", snap9[23:16], 8'd1);
        checkOutput("pix9_byte5", snap9[47:40], 8'd5);
        if (PAD) begin
            checkOutput("pix9_pad_bytes", {snap9[39:24], snap9[15:0]}, 32'd0);
        end

        // Back-pressure while a new pixel is being offered
        doReset(2);
        applyStimulus(8'h21, ok);
        waitPresent("bp_first", ok);
        rts_i    = 1'b1;
        pixel_in = 8'h22;
        snap     = tap_vec();
        for (int i = 0; i < 10; i++) begin
            checkOutput($sformatf("bp%0d_rts_ii", i), rts_ii, 1);
            checkOutput($sformatf("bp%0d_rtr_i", i), rtr_i, 0);
            checkOutput($sformatf("bp%0d_taps", i), tap_vec(), snap);
            tick();
        end
        rtr_ii = 1'b1;
        tick();
        checkOutput("bp_done_rts_ii", rts_ii, 0);
        checkOutput("bp_done_rtr_i", rtr_i, 0);
        tick();
        checkOutput("bp_idle_rtr_i", rtr_i, 1);
        tick();
        rts_i = 1'b0;
        waitPresent("bp_second", ok);
        checkOutput("bp_second_col", col_idx, 1);
        checkOutput("bp_second_row", row_idx, 0);
        tick();

        // Reset while presenting
        rtr_ii = 1'b0;
        applyStimulus(8'h23, ok);
        waitPresent("mid_present", ok);
        checkOutput("mid_col_before", col_idx, 2);
        rst = 1'b1;
        tick();
        checkOutput("mid_rst_rts_ii", rts_ii, 0);
        checkOutput("mid_rst_rtr_i", rtr_i, 0);
        checkOutput("mid_rst_taps", tap_vec(), 0);
        rst    = 1'b0;
        rtr_ii = 1'b1;
        applyStimulus(8'h24, ok);
        waitPresent("mid_after", ok);
        checkOutput("mid_after_col", col_idx, 0);
        checkOutput("mid_after_row", row_idx, 0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
